// File: rtl/sram_access_ctrl.sv
// Purpose : valid/ready access controller sequencing write/sense phases of one compiled SRAM array.
// Latency : read rsp after SENSE_CYCLES edges, write rsp after WRITE_CYCLES+1 edges, range error after 1 edge.
// Backpr. : one request in flight; req_ready low from accept until the response cycle.
//
// Ports   : clk/resetn (async active-low); req_* request port; rsp_* response port;
//           mem_* drive the array macro (mem_dout is the sense-amp output).
// Option  : define SRAM_CTRL_PARITY_EN to store an even-parity bit in mem_din[DATA_W]
//           and flag rsp_err on reads whose full sensed word has odd parity.
module sram_access_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 12,
    parameter int DEPTH        = 4096,
    parameter int SENSE_CYCLES = 2,
    parameter int WRITE_CYCLES = 2,
`ifdef SRAM_CTRL_PARITY_EN
    localparam int MW = DATA_W + 1
`else
    localparam int MW = DATA_W
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MW-1:0]     mem_din,
    input  logic [MW-1:0]     mem_dout,
    output logic              mem_write_en,
    output logic              mem_sense_en
);
    localparam int MAXC = (SENSE_CYCLES > WRITE_CYCLES) ? SENSE_CYCLES : WRITE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    // Counter is loaded with N-1 and the phase ends on the cycle it reads zero.
    localparam logic [CW-1:0]   SENSE_LD = CW'(SENSE_CYCLES - 1);
    localparam logic [CW-1:0]   WRITE_LD = CW'(WRITE_CYCLES - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              ready_nxt, valid_nxt, err_nxt, we_nxt, se_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [MW-1:0]     din_nxt;
    logic [MW-1:0]     din_req;
    logic              rd_err;
    logic              in_range;

    assign in_range = ({1'b0, req_addr} < DEPTH_L);

`ifdef SRAM_CTRL_PARITY_EN
    assign din_req = {^req_wdata, req_wdata};
    assign rd_err  = ^mem_dout;
`else
    assign din_req = req_wdata;
    assign rd_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_write_en <= 1'b0;
            mem_sense_en <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            req_ready    <= ready_nxt;
            rsp_valid    <= valid_nxt;
            rsp_err      <= err_nxt;
            rsp_rdata    <= rdata_nxt;
            mem_addr     <= addr_nxt;
            mem_din      <= din_nxt;
            mem_write_en <= we_nxt;
            mem_sense_en <= se_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_nxt = req_ready;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        rdata_nxt = rsp_rdata;
        addr_nxt  = mem_addr;
        din_nxt   = mem_din;
        we_nxt    = mem_write_en;
        se_nxt    = mem_sense_en;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_nxt = req_addr;
                    din_nxt  = din_req;
                    if (!in_range) begin
                        // Rejected without touching the array; stay ready.
                        valid_nxt = 1'b1;
                        err_nxt   = 1'b1;
                    end else if (req_we) begin
                        state_nxt = WRITE;
                        cnt_nxt   = WRITE_LD;
                        ready_nxt = 1'b0;
                        we_nxt    = 1'b1;
                    end else begin
                        state_nxt = READ;
                        cnt_nxt   = SENSE_LD;
                        ready_nxt = 1'b0;
                        se_nxt    = 1'b1;
                    end
                end
            end
            READ: begin
                if (cnt == '0) begin
                    rdata_nxt = mem_dout[DATA_W-1:0];
                    err_nxt   = rd_err;
                    valid_nxt = 1'b1;
                    ready_nxt = 1'b1;
                    se_nxt    = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WRITE: begin
                if (cnt == '0) begin
                    we_nxt    = 1'b0;
                    state_nxt = RECOVER;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RECOVER: begin
                valid_nxt = 1'b1;
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Parametrised access controller for the compiled SRAM array macros. It replaces free-running `write_en`/`sense_en` toggling with a valid/ready request port, then sequences the macro's write and sense phases for a programmable number of cycles. It returns one response per request, with read data and an error flag. It sits between the DPE datapath and one compiled array instance of any width or depth.

## Interface
Parameters:
- `DATA_W`, 8: user data width.
- `ADDR_W`, 12: address width.
- `DEPTH`, 4096: number of implemented words. Must satisfy DEPTH ≤ 2^ADDR_W.
- `SENSE_CYCLES`, 2: cycles `mem_sense_en` is held per read. Must be ≥ 1.
- `WRITE_CYCLES`, 2: cycles `mem_write_en` is held per write. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  DATA_W  read data. Holds until the next successful read.
- `rsp_err`  out  1  error flag, qualified by `rsp_valid`.
- `mem_addr`  out  ADDR_W  array address.
- `mem_din`  out  MW  array write data.
- `mem_dout`  in  MW  array sense-amp output.
- `mem_write_en`  out  1  array write enable.
- `mem_sense_en`  out  1  array sense enable.

MW = DATA_W, or DATA_W+1 with parity (see Configuration).

## Operation
- State machine: IDLE, READ, WRITE, RECOVER.
- IDLE:
  - `req_ready`=1; all other states 0.
  - On `req_valid & req_ready`, the request is captured into `mem_addr`/`mem_din`.
  - If `req_addr` ≥ DEPTH: no array access; go to IDLE with `rsp_valid`=1, `rsp_err`=1.
  - Otherwise, go to READ (`req_we`=0) or WRITE (`req_we`=1) and load the phase counter.
- READ:
  - `mem_sense_en`=1 for SENSE_CYCLES cycles.
  - On the last cycle, capture `mem_dout` into `rsp_rdata`, then go to IDLE with `rsp_valid`=1 and `rsp_err`=0 (parity excepted).
- WRITE:
  - `mem_write_en`=1 for WRITE_CYCLES cycles, then go to RECOVER.
- RECOVER:
  - Exactly one cycle with both enables low.
  - Then go to IDLE with `rsp_valid`=1, `rsp_err`=0.
- Enable exclusivity: `mem_write_en` and `mem_sense_en` are never high in the same cycle.
- Held signals:
  - `mem_addr`/`mem_din` stay stable for the whole access and hold afterwards until the next accept.
  - `rsp_rdata` is unchanged by writes and by errored requests.
- Phase counter width: $clog2(max(SENSE_CYCLES, WRITE_CYCLES)+1).
- Request inputs are ignored while `req_ready`=0.

## Timing
- All outputs are registered.
- Reset values:
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0.
  - `rsp_rdata`=0, `mem_addr`=0, `mem_din`=0.
  - `mem_write_en`=0, `mem_sense_en`=0.
  - State = IDLE.
- Read issued at accept edge E0:
  - `mem_sense_en` is high from E0 to E0+SENSE_CYCLES.
  - `rsp_valid` and `req_ready` are high in the cycle after edge E0+SENSE_CYCLES.
  - A back-to-back accept is allowed in that same cycle.
- Write issued at E0:
  - `mem_write_en` is high from E0 to E0+WRITE_CYCLES.
  - RECOVER runs one cycle.
  - `rsp_valid`/`req_ready` go high after edge E0+WRITE_CYCLES+1.
- Out-of-range request: `rsp_valid` is high in the cycle immediately after the accept edge.
- `resetn` asserted mid-access:
  - Immediately returns all outputs to reset values and aborts the access.
  - No response is issued.
  - The contents of the word being written are undefined.

## Configuration
- `SRAM_CTRL_PARITY_EN` defined:
  - MW = DATA_W+1; `mem_din[DATA_W]` = even parity (XOR) of `req_wdata`.
  - On read completion, `rsp_err`=1 if the XOR of all MW `mem_dout` bits is 1.
  - `rsp_rdata` = `mem_dout[DATA_W-1:0]` regardless of the parity result.
- Not defined:
  - MW = DATA_W; no parity logic.
  - `rsp_err` is set only for out-of-range addresses.

## Test plan
- Reset release, then write 0xA5 to address 0x003, then read 0x003:
  - `rsp_rdata`=0xA5 and `rsp_err`=0.
  - Write response arrives 4 cycles after accept and read response 3 cycles after accept (defaults).
- Hold `req_valid` continuously for write 0x3C@0x000, read@0x000, read@0x001 (0x001 preloaded with 0x5A):
  - Reads return 0x3C then 0x5A.
  - `req_ready` is low during every access.
  - The enables are never high together.
- DEPTH=3000, read at 0xBB8:
  - `rsp_valid`=1 and `rsp_err`=1 one cycle after accept.
  - No enable toggles; `rsp_rdata` is unchanged.
- SENSE_CYCLES=4, WRITE_CYCLES=1:
  - `mem_sense_en` is high for exactly 4 cycles.
  - `mem_write_en` is high for 1 cycle, followed by 1 RECOVER cycle.
- Drop `resetn` in the second WRITE cycle:
  - All outputs read 0 and `req_ready`=1 immediately.
  - No `rsp_valid` appears after release.
- With `SRAM_CTRL_PARITY_EN`, write 0x07, then corrupt one `mem_dout` bit in the array model:
  - Read returns `rsp_err`=1.
  - The uncorrupted read returns `rsp_err`=0.
